id_pipe: RTL and testbench

ID_PIPE -- requirements
Module: id_pipe

---
 rtl/id_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_id_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_pipe.sv
// Instruction decode stage for RV32IM: decode, regfile read, hazard check, one output register.
// Latency 1 cycle; ready_i low holds the output register and deasserts inst_ready_o; hazards insert bubbles.
// Defining ID_FWD_EN enables EX/MEM operand forwarding (only an EX load match then stalls).
module id_pipe #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            inst_i,
  input  logic [XLEN-1:0]        inst_addr_i,
  input  logic                   inst_valid_i,
  output logic                   inst_ready_o,
  input  logic                   flush_i,
  output logic [4:0]             reg_raddr1_o,
  output logic [4:0]             reg_raddr2_o,
  input  logic [XLEN-1:0]        reg_rdata1_i,
  input  logic [XLEN-1:0]        reg_rdata2_i,
  input  logic                   ex_we_i,
  input  logic [4:0]             ex_waddr_i,
  input  logic [XLEN-1:0]        ex_wdata_i,
  input  logic                   ex_is_load_i,
  input  logic                   mem_we_i,
  input  logic [4:0]             mem_waddr_i,
  input  logic [XLEN-1:0]        mem_wdata_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [31:0]            inst_o,
  output logic [XLEN-1:0]        inst_addr_o,
  output logic [4:0]             reg_waddr_o,
  output logic                   reg_we_o,
  output logic [XLEN-1:0]        op1_o,
  output logic [XLEN-1:0]        op2_o,
  output logic                   illegal_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic {EMPTY, FULL} state_t;
  // SEL_IMM means the U-immediate on op1 and the I-immediate on op2
  typedef enum logic [1:0] {SEL_ZERO, SEL_RS, SEL_IMM, SEL_PC} sel_t;

  state_t state_q, state_d;
  sel_t   op1_sel, op2_sel;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rs1, rs2, rd;
  logic            use_rs1, use_rs2, dec_we, dec_ill;
  logic [XLEN-1:0] imm_i, imm_u, rs1_val, rs2_val, dec_op1, dec_op2;
  logic            ex_m1, ex_m2, mem_m1, mem_m2, hz1, hz2, hazard;
  logic            xfer_in, load_out;

  assign opcode = inst_i[6:0];
  assign rd     = inst_i[11:7];
  assign funct3 = inst_i[14:12];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];
  assign funct7 = inst_i[31:25];
  assign imm_i  = XLEN'($signed(inst_i[31:20]));
  assign imm_u  = XLEN'($signed({inst_i[31:12], 12'b0}));

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    dec_we  = 1'b0;
    dec_ill = 1'b0;
    op1_sel = SEL_ZERO;
    op2_sel = SEL_ZERO;
    case (opcode)
      OPC_OP_IMM: begin
        use_rs1 = 1'b1; dec_we = 1'b1; op1_sel = SEL_RS; op2_sel = SEL_IMM;
        if (funct3 == 3'b001)
          dec_ill = (funct7 != 7'h00);
        else if (funct3 == 3'b101)
          dec_ill = (funct7 != 7'h00) && (funct7 != 7'h20);
      end
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; dec_we = 1'b1; op1_sel = SEL_RS; op2_sel = SEL_RS;
        if (funct7 == 7'h20)
          dec_ill = (funct3 != 3'b000) && (funct3 != 3'b101);
        else
          dec_ill = (funct7 != 7'h00) && (funct7 != 7'h01);
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; op1_sel = SEL_RS; op2_sel = SEL_RS;
        dec_ill = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; op1_sel = SEL_RS; op2_sel = SEL_RS;
        dec_ill = (funct3 > 3'b010);
      end
      OPC_LOAD: begin
        use_rs1 = 1'b1; dec_we = 1'b1; op1_sel = SEL_RS; op2_sel = SEL_IMM;
        dec_ill = (funct3 == 3'b011) || (funct3 > 3'b101);
      end
      OPC_JAL: dec_we = 1'b1;
      OPC_JALR: begin
        use_rs1 = 1'b1; dec_we = 1'b1; op1_sel = SEL_RS; op2_sel = SEL_IMM;
        dec_ill = (funct3 != 3'b000);
      end
      OPC_LUI:   begin dec_we = 1'b1; op1_sel = SEL_IMM; end
      OPC_AUIPC: begin dec_we = 1'b1; op1_sel = SEL_IMM; op2_sel = SEL_PC; end
      default:   dec_ill = 1'b1;
    endcase
    // An illegal instruction reads nothing and writes nothing
    if (dec_ill) begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      dec_we  = 1'b0;
      op1_sel = SEL_ZERO;
      op2_sel = SEL_ZERO;
    end
  end

  assign reg_raddr1_o = use_rs1 ? rs1 : 5'd0;
  assign reg_raddr2_o = use_rs2 ? rs2 : 5'd0;

  assign ex_m1  = ex_we_i  && (reg_raddr1_o != 5'd0) && (ex_waddr_i  == reg_raddr1_o);
  assign ex_m2  = ex_we_i  && (reg_raddr2_o != 5'd0) && (ex_waddr_i  == reg_raddr2_o);
  assign mem_m1 = mem_we_i && (reg_raddr1_o != 5'd0) && (mem_waddr_i == reg_raddr1_o);
  assign mem_m2 = mem_we_i && (reg_raddr2_o != 5'd0) && (mem_waddr_i == reg_raddr2_o);

`ifdef ID_FWD_EN
  assign hz1     = ex_m1 && ex_is_load_i;
  assign hz2     = ex_m2 && ex_is_load_i;
  assign rs1_val = ex_m1 ? ex_wdata_i : (mem_m1 ? mem_wdata_i : reg_rdata1_i);
  assign rs2_val = ex_m2 ? ex_wdata_i : (mem_m2 ? mem_wdata_i : reg_rdata2_i);
`else
  logic unused_fwd;
  assign unused_fwd = ex_is_load_i ^ (^ex_wdata_i) ^ (^mem_wdata_i);
  assign hz1     = ex_m1 || mem_m1;
  assign hz2     = ex_m2 || mem_m2;
  assign rs1_val = reg_rdata1_i;
  assign rs2_val = reg_rdata2_i;
`endif

  always_comb begin
    case (op1_sel)
      SEL_RS:  dec_op1 = rs1_val;
      SEL_IMM: dec_op1 = imm_u;
      default: dec_op1 = '0;
    endcase
    case (op2_sel)
      SEL_RS:  dec_op2 = rs2_val;
      SEL_IMM: dec_op2 = imm_i;
      SEL_PC:  dec_op2 = inst_addr_i;
      default: dec_op2 = '0;
    endcase
  end

  assign hazard       = inst_valid_i && (hz1 || hz2);
  assign valid_o      = (state_q == FULL);
  assign inst_ready_o = !hazard && (!valid_o || ready_i);
  assign xfer_in      = inst_valid_i && inst_ready_o;
  assign load_out     = xfer_in && !flush_i;

  always_comb begin
    state_d = state_q;
    if (flush_i)
      state_d = EMPTY;
    else if (xfer_in)
      state_d = FULL;
    else if (state_q == FULL && ready_i)
      state_d = EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_o      <= '0;
      inst_addr_o <= '0;
      reg_waddr_o <= '0;
      reg_we_o    <= 1'b0;
      op1_o       <= '0;
      op2_o       <= '0;
      illegal_o   <= 1'b0;
    end else if (load_out) begin
      inst_o      <= inst_i;
      inst_addr_o <= inst_addr_i;
      reg_waddr_o <= dec_we ? rd : 5'd0;
      reg_we_o    <= dec_we;
      op1_o       <= dec_op1;
      op2_o       <= dec_op2;
      illegal_o   <= dec_ill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_o <= '0;
    else if (hazard && !flush_i && (stall_cnt_o != '1))
      stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
  end

endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe: decode table plus hand-written hazard, backpressure, flush and reset sequences.
module tb_id_pipe;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   inst_i, inst_addr_i;
  logic          inst_valid_i, inst_ready_o, flush_i;
  logic [4:0]    reg_raddr1_o, reg_raddr2_o;
  logic [31:0]   reg_rdata1_i, reg_rdata2_i;
  logic          ex_we_i, ex_is_load_i, mem_we_i;
  logic [4:0]    ex_waddr_i, mem_waddr_i;
  logic [31:0]   ex_wdata_i, mem_wdata_i;
  logic          valid_o, ready_i;
  logic [31:0]   inst_o, inst_addr_o, op1_o, op2_o;
  logic [4:0]    reg_waddr_o;
  logic          reg_we_o, illegal_o;
  logic [CW-1:0] stall_cnt_o;

  int n_cmp = 0;
  int n_fail = 0;
  logic [CW-1:0] exp_stall;

  id_pipe #(.XLEN(32), .STALL_CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .inst_valid_i(inst_valid_i),
    .inst_ready_o(inst_ready_o), .flush_i(flush_i),
    .reg_raddr1_o(reg_raddr1_o), .reg_raddr2_o(reg_raddr2_o),
    .reg_rdata1_i(reg_rdata1_i), .reg_rdata2_i(reg_rdata2_i),
    .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o),
    .op1_o(op1_o), .op2_o(op2_o), .illegal_o(illegal_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  // Regfile contents: x2 = 10, otherwise xN = N * 0x11
  function automatic logic [31:0] regval(input logic [4:0] a);
    return (a == 5'd2) ? 32'd10 : 32'(a) * 32'h11;
  endfunction
  assign reg_rdata1_i = regval(reg_raddr1_o);
  assign reg_rdata2_i = regval(reg_raddr2_o);

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  ra1, ra2;
    logic [31:0] op1, op2;
    logic [4:0]  wa;
    logic        we, ill;
  } vec_t;
  vec_t vecs[15];

  localparam logic [31:0] PC   = 32'h0000_1000;
  localparam logic [31:0] ADDI = 32'hFFB10093;
  localparam logic [31:0] ADD1 = 32'h002081B3;
  localparam logic [31:0] ADD5 = 32'h006281B3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] o1, input logic [31:0] o2,
                         input logic [4:0] wa, input logic we, input logic ill);
    chk({tag, "_valid"}, 32'(valid_o), 32'(v));
    chk({tag, "_op1"}, op1_o, o1);
    chk({tag, "_op2"}, op2_o, o2);
    chk({tag, "_waddr"}, 32'(reg_waddr_o), 32'(wa));
    chk({tag, "_we"}, 32'(reg_we_o), 32'(we));
    chk({tag, "_ill"}, 32'(illegal_o), 32'(ill));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == '1) ? c : c + CW'(1);
  endfunction

  initial begin
    vecs[0]  = '{ADDI,         5'd2, 5'd0, 32'd10,       32'hFFFFFFFB, 5'd1,  1'b1, 1'b0};
    vecs[1]  = '{ADD5,         5'd5, 5'd6, 32'h55,       32'h66,       5'd3,  1'b1, 1'b0};
    vecs[2]  = '{32'h02628233, 5'd5, 5'd6, 32'h55,       32'h66,       5'd4,  1'b1, 1'b0};
    vecs[3]  = '{32'h406283B3, 5'd5, 5'd6, 32'h55,       32'h66,       5'd7,  1'b1, 1'b0};
    vecs[4]  = '{32'h40629233, 5'd0, 5'd0, 32'h0,        32'h0,        5'd0,  1'b0, 1'b1};
    vecs[5]  = '{32'h00628463, 5'd5, 5'd6, 32'h55,       32'h66,       5'd0,  1'b0, 1'b0};
    vecs[6]  = '{32'h0062A223, 5'd5, 5'd6, 32'h55,       32'h66,       5'd0,  1'b0, 1'b0};
    vecs[7]  = '{32'h010000EF, 5'd0, 5'd0, 32'h0,        32'h0,        5'd1,  1'b1, 1'b0};
    vecs[8]  = '{32'h00C380E7, 5'd7, 5'd0, 32'h77,       32'hC,        5'd1,  1'b1, 1'b0};
    vecs[9]  = '{32'h12345537, 5'd0, 5'd0, 32'h12345000, 32'h0,        5'd10, 1'b1, 1'b0};
    vecs[10] = '{32'hFFFFF597, 5'd0, 5'd0, 32'hFFFFF000, PC,           5'd11, 1'b1, 1'b0};
    vecs[11] = '{32'hFFC2A603, 5'd5, 5'd0, 32'h55,       32'hFFFFFFFC, 5'd12, 1'b1, 1'b0};
    vecs[12] = '{32'h0000007F, 5'd0, 5'd0, 32'h0,        32'h0,        5'd0,  1'b0, 1'b1};
    vecs[13] = '{32'h00331293, 5'd6, 5'd0, 32'h66,       32'h3,        5'd5,  1'b1, 1'b0};
    vecs[14] = '{32'hFFC2B603, 5'd0, 5'd0, 32'h0,        32'h0,        5'd0,  1'b0, 1'b1};

    rst = 1'b1; inst_i = 32'h0; inst_addr_i = PC; inst_valid_i = 1'b0; flush_i = 1'b0;
    ex_we_i = 1'b0; ex_waddr_i = 5'd0; ex_wdata_i = 32'h0; ex_is_load_i = 1'b0;
    mem_we_i = 1'b0; mem_waddr_i = 5'd0; mem_wdata_i = 32'h0; ready_i = 1'b1;
    exp_stall = '0;
    tick(); tick();
    chk_out("reset", 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("reset_stall", 32'(stall_cnt_o), 32'h0);
    chk("reset_inst", inst_o, 32'h0);
    rst = 1'b0;
    tick();

    // Decode table, one instruction per cycle with the consumer always ready
    for (int i = 0; i < 15; i++) begin
      inst_i = vecs[i].inst; inst_valid_i = 1'b1;
      #1;
      chk($sformatf("v%0d_rdy", i), 32'(inst_ready_o), 32'h1);
      chk($sformatf("v%0d_ra1", i), 32'(reg_raddr1_o), 32'(vecs[i].ra1));
      chk($sformatf("v%0d_ra2", i), 32'(reg_raddr2_o), 32'(vecs[i].ra2));
      tick();
      chk_out($sformatf("v%0d", i), 1'b1, vecs[i].op1, vecs[i].op2, vecs[i].wa, vecs[i].we, vecs[i].ill);
      chk($sformatf("v%0d_inst", i), inst_o, vecs[i].inst);
    end

    // EX producer of x1, not a load
    inst_i = ADD1; ex_we_i = 1'b1; ex_waddr_i = 5'd1; ex_wdata_i = 32'd7;
    #1;
`ifdef ID_FWD_EN
    chk("exfwd_rdy", 32'(inst_ready_o), 32'h1);
    tick();
    chk_out("exfwd", 1'b1, 32'd7, 32'd10, 5'd3, 1'b1, 1'b0);
    chk("exfwd_stall", 32'(stall_cnt_o), 32'(exp_stall));
    ex_we_i = 1'b0;
`else
    chk("exhz_rdy", 32'(inst_ready_o), 32'h0);
    tick();
    exp_stall = sat_inc(exp_stall);
    chk("exhz_stall", 32'(stall_cnt_o), 32'(exp_stall));
    chk("exhz_bubble", 32'(valid_o), 32'h0);
    ex_we_i = 1'b0;
    #1;
    chk("exhz_rdy2", 32'(inst_ready_o), 32'h1);
    tick();
    chk_out("exhz_go", 1'b1, 32'h11, 32'd10, 5'd3, 1'b1, 1'b0);
`endif

    // Load-use: load in EX for one cycle, then in MEM
    ex_we_i = 1'b1; ex_waddr_i = 5'd1; ex_wdata_i = 32'd7; ex_is_load_i = 1'b1;
    #1;
    chk("ld_rdy", 32'(inst_ready_o), 32'h0);
    tick();
    exp_stall = sat_inc(exp_stall);
    chk("ld_stall", 32'(stall_cnt_o), 32'(exp_stall));
    chk("ld_bubble", 32'(valid_o), 32'h0);
    ex_we_i = 1'b0; ex_is_load_i = 1'b0;
    mem_we_i = 1'b1; mem_waddr_i = 5'd1; mem_wdata_i = 32'h99;
    #1;
`ifdef ID_FWD_EN
    chk("ldmem_rdy", 32'(inst_ready_o), 32'h1);
    tick();
    chk_out("ldmem", 1'b1, 32'h99, 32'd10, 5'd3, 1'b1, 1'b0);
    chk("ldmem_stall", 32'(stall_cnt_o), 32'(exp_stall));
    mem_we_i = 1'b0;
`else
    chk("ldmem_rdy", 32'(inst_ready_o), 32'h0);
    tick();
    exp_stall = sat_inc(exp_stall);
    chk("ldmem_stall", 32'(stall_cnt_o), 32'(exp_stall));
    mem_we_i = 1'b0;
    #1;
    chk("ldrf_rdy", 32'(inst_ready_o), 32'h1);
    tick();
    chk_out("ldrf", 1'b1, 32'h11, 32'd10, 5'd3, 1'b1, 1'b0);
`endif

    // Backpressure: held output, new instruction waits
    inst_i = ADDI;
    tick();
    ready_i = 1'b0; inst_i = ADD5;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_rdy", c), 32'(inst_ready_o), 32'h0);
      tick();
      chk_out($sformatf("bp%0d", c), 1'b1, 32'd10, 32'hFFFFFFFB, 5'd1, 1'b1, 1'b0);
      chk($sformatf("bp%0d_inst", c), inst_o, ADDI);
    end
    chk("bp_stall", 32'(stall_cnt_o), 32'(exp_stall));
    ready_i = 1'b1;
    #1;
    chk("bp_rel_rdy", 32'(inst_ready_o), 32'h1);
    tick();
    chk("bp_rel_inst", inst_o, ADD5);
    chk("bp_rel_op1", op1_o, 32'h55);

    // Flush overrides the transfer; a flushed hazard is not counted
    inst_i = ADDI; flush_i = 1'b1;
    tick();
    chk("flush_valid", 32'(valid_o), 32'h0);
    chk("flush_inst", inst_o, ADD5);
    ex_we_i = 1'b1; ex_waddr_i = 5'd2; ex_is_load_i = 1'b1;
    tick();
    chk("flushhz_stall", 32'(stall_cnt_o), 32'(exp_stall));
    chk("flushhz_valid", 32'(valid_o), 32'h0);
    flush_i = 1'b0; ex_we_i = 1'b0; ex_is_load_i = 1'b0; inst_valid_i = 1'b0;
    tick();
    chk("idle_valid", 32'(valid_o), 32'h0);

    // Reset asserted mid-stall
    inst_valid_i = 1'b1; inst_i = ADDI;
    tick();
    ready_i = 1'b0; inst_i = ADD1; ex_we_i = 1'b1; ex_waddr_i = 5'd1; ex_is_load_i = 1'b1;
    tick();
    exp_stall = sat_inc(exp_stall);
    chk("rs_stall_pre", 32'(stall_cnt_o), 32'(exp_stall));
    chk("rs_valid_pre", 32'(valid_o), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk_out("rs_async", 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("rs_async_stall", 32'(stall_cnt_o), 32'h0);
    chk("rs_async_inst", inst_o, 32'h0);
    exp_stall = '0;
    tick();
    rst = 1'b0; ex_we_i = 1'b0; ex_is_load_i = 1'b0; inst_i = ADDI; ready_i = 1'b1;
    #1;
    chk("rs_rel_rdy", 32'(inst_ready_o), 32'h1);
    tick();
    chk_out("rs_rel", 1'b1, 32'd10, 32'hFFFFFFFB, 5'd1, 1'b1, 1'b0);

    // Stall counter saturation
    ex_we_i = 1'b1; ex_waddr_i = 5'd2; ex_is_load_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      exp_stall = sat_inc(exp_stall);
      chk($sformatf("sat%0d", c), 32'(stall_cnt_o), 32'(exp_stall));
    end
    chk("sat_final", 32'(stall_cnt_o), 32'hF);
    ex_we_i = 1'b0; ex_is_load_i = 1'b0; inst_valid_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
